// File: rtl/bu_ntt_unified_if.sv
// Operation/result bus of the NTT/INTT butterfly: operands and tag in, results and tag out.
interface bu_ntt_unified_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             mode;
    logic [WIDTH-1:0] A_In;
    logic [WIDTH-1:0] B_In;
    logic [WIDTH-1:0] W_In;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic [WIDTH-1:0] A_Out;
    logic [WIDTH-1:0] B_Out;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, mode, A_In, B_In, W_In, tag_in,
        input  out_valid, A_Out, B_Out, tag_out
    );

    modport slave (
        input  in_valid, mode, A_In, B_In, W_In, tag_in,
        output out_valid, A_Out, B_Out, tag_out
    );
endinterface

// File: rtl/bu_ntt_unified.sv
// Unified CT (NTT) / GS (INTT) modular butterfly, 5-stage fixed-latency pipeline with
// per-stage mode bit, Barrett reduction and a global clock-enable that freezes every stage.
module bu_ntt_unified #(
    parameter int WIDTH = 16,
    parameter int Q     = 3329,
    parameter int TAG_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    input logic               ce,
    bu_ntt_unified_if.slave   bus
);
    localparam int              PW        = 2 * WIDTH;
    localparam logic [WIDTH-1:0] QW       = WIDTH'(Q);
    localparam logic [PW-1:0]   QP        = PW'(Q);
    localparam logic [PW:0]     R2K       = {1'b1, {PW{1'b0}}};
    localparam logic [PW-1:0]   BARRETT_K = PW'(R2K / (PW + 1)'(Q));

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, QW}) s = s - {1'b0, QW};
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        if (x >= y) return x - y;
        return x + QW - y;
    endfunction

    // Quotient estimate is at most one short, so a single conditional subtract makes it exact.
    function automatic logic [WIDTH-1:0] barrett(input logic [PW-1:0] x);
        logic [PW-1:0] qe;
        logic [PW-1:0] r;
        qe = PW'(({{PW{1'b0}}, x} * {{PW{1'b0}}, BARRETT_K}) >> PW);
        r  = x - qe * QP;
        if (r >= QP) r = r - QP;
        return r[WIDTH-1:0];
    endfunction

    logic             vld_p1_q, vld_p1_d, mode_p1_q, mode_p1_d;
    logic [TAG_W-1:0] tag_p1_q, tag_p1_d;
    logic [WIDTH-1:0] a_p1_q, a_p1_d, b_p1_q, b_p1_d, w_p1_q, w_p1_d;

    logic             vld_p2_q, vld_p2_d, mode_p2_q, mode_p2_d;
    logic [TAG_W-1:0] tag_p2_q, tag_p2_d;
    logic [PW-1:0]    prod_p2_q, prod_p2_d;
    logic [WIDTH-1:0] s_p2_q, s_p2_d, d_p2_q, d_p2_d, w_p2_q, w_p2_d;

    logic             vld_p3_q, vld_p3_d, mode_p3_q, mode_p3_d;
    logic [TAG_W-1:0] tag_p3_q, tag_p3_d;
    logic [PW-1:0]    x_p3_q, x_p3_d;
    logic [WIDTH-1:0] s_p3_q, s_p3_d;

    logic             vld_p4_q, vld_p4_d;
    logic [TAG_W-1:0] tag_p4_q, tag_p4_d;
    logic [WIDTH-1:0] ao_p4_q, ao_p4_d, bo_p4_q, bo_p4_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
    logic [TAG_W-1:0] tag_out_q, tag_out_d;

    always_comb begin
        vld_p1_d  = bus.in_valid;
        mode_p1_d = bus.mode;
        tag_p1_d  = bus.tag_in;
        a_p1_d    = bus.A_In;
        b_p1_d    = bus.B_In;
        w_p1_d    = bus.W_In;

        // S2: CT forms w*b; GS forms sum and difference (product reg loads regardless)
        vld_p2_d  = vld_p1_q;
        mode_p2_d = mode_p1_q;
        tag_p2_d  = tag_p1_q;
        prod_p2_d = {{WIDTH{1'b0}}, w_p1_q} * {{WIDTH{1'b0}}, b_p1_q};
        s_p2_d    = mode_p1_q ? mod_add(a_p1_q, b_p1_q) : a_p1_q;
        d_p2_d    = mod_sub(a_p1_q, b_p1_q);
        w_p2_d    = w_p1_q;

        // S3: CT reduces w*b; GS forms diff*w
        vld_p3_d  = vld_p2_q;
        mode_p3_d = mode_p2_q;
        tag_p3_d  = tag_p2_q;
        x_p3_d    = mode_p2_q ? {{WIDTH{1'b0}}, d_p2_q} * {{WIDTH{1'b0}}, w_p2_q}
                              : {{WIDTH{1'b0}}, barrett(prod_p2_q)};
        s_p3_d    = s_p2_q;

        // S4: CT add/sub of the reduced product; GS reduces diff*w
        vld_p4_d  = vld_p3_q;
        tag_p4_d  = tag_p3_q;
        if (mode_p3_q) begin
            ao_p4_d = s_p3_q;
            bo_p4_d = barrett(x_p3_q);
        end else begin
            ao_p4_d = mod_add(s_p3_q, x_p3_q[WIDTH-1:0]);
            bo_p4_d = mod_sub(s_p3_q, x_p3_q[WIDTH-1:0]);
        end

        // S5: result registers keep their last value across idle slots
        out_valid_d = vld_p4_q;
        a_out_d     = vld_p4_q ? ao_p4_q  : a_out_q;
        b_out_d     = vld_p4_q ? bo_p4_q  : b_out_q;
        tag_out_d   = vld_p4_q ? tag_p4_q : tag_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0; mode_p1_q <= 1'b0; tag_p1_q <= '0;
            a_p1_q <= '0; b_p1_q <= '0; w_p1_q <= '0;
            vld_p2_q <= 1'b0; mode_p2_q <= 1'b0; tag_p2_q <= '0;
            prod_p2_q <= '0; s_p2_q <= '0; d_p2_q <= '0; w_p2_q <= '0;
            vld_p3_q <= 1'b0; mode_p3_q <= 1'b0; tag_p3_q <= '0;
            x_p3_q <= '0; s_p3_q <= '0;
            vld_p4_q <= 1'b0; tag_p4_q <= '0; ao_p4_q <= '0; bo_p4_q <= '0;
            out_valid_q <= 1'b0; a_out_q <= '0; b_out_q <= '0; tag_out_q <= '0;
        end else if (ce) begin
            vld_p1_q <= vld_p1_d; mode_p1_q <= mode_p1_d; tag_p1_q <= tag_p1_d;
            a_p1_q <= a_p1_d; b_p1_q <= b_p1_d; w_p1_q <= w_p1_d;
            vld_p2_q <= vld_p2_d; mode_p2_q <= mode_p2_d; tag_p2_q <= tag_p2_d;
            prod_p2_q <= prod_p2_d; s_p2_q <= s_p2_d; d_p2_q <= d_p2_d; w_p2_q <= w_p2_d;
            vld_p3_q <= vld_p3_d; mode_p3_q <= mode_p3_d; tag_p3_q <= tag_p3_d;
            x_p3_q <= x_p3_d; s_p3_q <= s_p3_d;
            vld_p4_q <= vld_p4_d; tag_p4_q <= tag_p4_d; ao_p4_q <= ao_p4_d; bo_p4_q <= bo_p4_d;
            out_valid_q <= out_valid_d; a_out_q <= a_out_d; b_out_q <= b_out_d; tag_out_q <= tag_out_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.A_Out     = a_out_q;
    assign bus.B_Out     = b_out_q;
    assign bus.tag_out   = tag_out_q;
endmodule

// File: tb/tb_bu_ntt_unified.sv
// Bench for bu_ntt_unified: vector table, random back-to-back run, stall and reset sequences.
module tb_bu_ntt_unified;
    localparam int WIDTH = 16;
    localparam int Q     = 3329;
    localparam int TAG_W = 8;

    typedef struct {
        logic m;
        int   a, b, w, ea, eb;
    } vec_t;

    typedef struct {
        int a, b, tag, at_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic ce;
    always #5 clk = ~clk;

    bu_ntt_unified_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();
    bu_ntt_unified #(.WIDTH(WIDTH), .Q(Q), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus.slave)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   en_cnt = 0;
    logic ce_e;
    exp_t sb[$];
    exp_t got;
    vec_t tbl[9];

    always @(posedge clk) if (rst_n && ce) en_cnt <= en_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic m, input int a, input int b, input int w,
                                  output int ea, output int eb);
        int t;
        if (!m) begin
            t  = (w * b) % Q;
            ea = (a + t) % Q;
            eb = (a + Q - t) % Q;
        end else begin
            ea = (a + b) % Q;
            eb = (((a + Q - b) % Q) * w) % Q;
        end
    endfunction

    // Scoreboard monitor: a result counts only on an enabled edge.
    always begin
        @(posedge clk);
        ce_e = ce;
        #1;
        if (ce_e && bus.out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got out_valid=1 tag=%0d expected no pending op", bus.tag_out);
            end else begin
                got = sb.pop_front();
                check("A_Out", int'(bus.A_Out), got.a);
                check("B_Out", int'(bus.B_Out), got.b);
                check("tag_out", int'(bus.tag_out), got.tag);
                check("latency_edge", en_cnt, got.at_edge);
            end
        end
    end

    task automatic issue(input logic m, input int a, input int b, input int w,
                         input int tg, input int ea, input int eb);
        exp_t e;
        @(negedge clk);
        ce           = 1'b1;
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.A_In     = WIDTH'(a);
        bus.B_In     = WIDTH'(b);
        bus.W_In     = WIDTH'(w);
        bus.tag_in   = TAG_W'(tg);
        e.a = ea; e.b = eb; e.tag = tg & 255; e.at_edge = en_cnt + 5;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while (sb.size() > 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic check_zero(input string tagname);
        check({tagname, "_out_valid"}, int'(bus.out_valid), 0);
        check({tagname, "_A_Out"}, int'(bus.A_Out), 0);
        check({tagname, "_B_Out"}, int'(bus.B_Out), 0);
        check({tagname, "_tag_out"}, int'(bus.tag_out), 0);
    endtask

    initial begin
        int   ea, eb, a, b, w;
        logic m;
        int   sa[3], sbv[3];

        tbl[0] = '{1'b0, 1, 1, 17, 18, 3313};
        tbl[1] = '{1'b1, 5, 3, 17, 8, 34};
        tbl[2] = '{1'b1, 3, 5, 17, 8, 3295};
        tbl[3] = '{1'b0, 3328, 3328, 3328, 0, 3327};
        tbl[4] = '{1'b1, 3328, 3328, 3328, 3327, 0};
        tbl[5] = '{1'b0, 0, 0, 0, 0, 0};
        tbl[6] = '{1'b1, 0, 3328, 1, 3328, 1};
        tbl[7] = '{1'b0, 3328, 1, 1, 0, 3327};
        tbl[8] = '{1'b0, 100, 2, 1000, 2100, 1429};

        rst_n = 1'b0; ce = 1'b1;
        bus.in_valid = 1'b0; bus.mode = 1'b0;
        bus.A_In = '0; bus.B_In = '0; bus.W_In = '0; bus.tag_in = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        idle(2);
        check_zero("post_reset");

        for (int i = 0; i < 9; i++)
            issue(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].w, i, tbl[i].ea, tbl[i].eb);
        idle(8);
        drain(20);

        for (int i = 0; i < 64; i++) begin
            m = 1'($urandom_range(0, 1));
            a = int'($urandom_range(0, Q - 1));
            b = int'($urandom_range(0, Q - 1));
            w = int'($urandom_range(0, Q - 1));
            model(m, a, b, w, ea, eb);
            issue(m, a, b, w, i, ea, eb);
        end
        idle(8);
        drain(20);

        for (int i = 0; i < 3; i++) begin
            m = 1'(i & 1);
            model(m, 1000 + i * 7, 2500 - i * 11, 1234 + i, sa[i], sbv[i]);
            issue(m, 1000 + i * 7, 2500 - i * 11, 1234 + i, 200 + i, sa[i], sbv[i]);
        end
        idle(2);
        @(negedge clk);
        ce = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_out_valid", int'(bus.out_valid), 1);
            check("stall_A_Out", int'(bus.A_Out), sa[0]);
            check("stall_B_Out", int'(bus.B_Out), sbv[0]);
            check("stall_tag_out", int'(bus.tag_out), 200);
        end
        ce = 1'b1;
        idle(8);
        drain(20);

        for (int i = 0; i < 4; i++) begin
            m = 1'($urandom_range(0, 1));
            a = int'($urandom_range(1, Q - 1));
            b = int'($urandom_range(1, Q - 1));
            w = int'($urandom_range(1, Q - 1));
            model(m, a, b, w, ea, eb);
            issue(m, a, b, w, 90 + i, ea, eb);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("inflight_reset");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_zero("after_reset_idle");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bu_ntt_unified.md
Name: bu_ntt_unified

Overview:
Parametrised modular butterfly unit for the NTT/INTT datapath of the ML-KEM core. It performs a Cooley-Tukey (forward NTT) or Gentleman-Sande (inverse NTT) butterfly, selected per operation. It has a fixed-latency valid/tag pipeline and a global clock-enable for stalling. It sits between the coefficient RAM read ports and write-back logic, and is driven by the NTT/INTT address-generation controller.

Parameters:
WIDTH, 16, coefficient/twiddle width; must satisfy 2*Q < 2^WIDTH
Q, 3329, modulus; Barrett constant is derived as a localparam, floor(2^(2*WIDTH)/Q)
TAG_W, 8, width of the sideband tag carried alongside each operation (write address, etc.)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
ce  in  1  pipeline enable; 0 freezes every pipeline register
in_valid  in  1  operation present on inputs this cycle
mode  in  1  0 = CT/NTT, 1 = GS/INTT; sampled with the operation
A_In  in  WIDTH  coefficient a, canonical [0,Q-1]
B_In  in  WIDTH  coefficient b, canonical [0,Q-1]
W_In  in  WIDTH  twiddle w, canonical [0,Q-1]
tag_in  in  TAG_W  sideband, passed through unchanged
out_valid  out  1  result present
A_Out  out  WIDTH  result a'
B_Out  out  WIDTH  result b'
tag_out  out  TAG_W  tag of the result

Behaviour:
- Reset: asynchronous on rst_n low. All pipeline data, mode, valid and tag registers clear. out_valid=0, A_Out=0, B_Out=0, tag_out=0 while reset is asserted and after release until the first result. Operations in flight when reset asserts are discarded.
- Arithmetic, all outputs canonical in [0,Q-1]:
  - mode 0: A' = (a + w*b) mod Q, B' = (a - w*b) mod Q
  - mode 1: A' = (a + b) mod Q, B' = ((a - b) * w) mod Q
- Modular add/sub use a conditional single correction (+Q or -Q). The product is 2*WIDTH bits wide. Barrett reduction includes a final conditional subtract so the result is exact.
- Inputs outside [0,Q-1] are out of contract; outputs are unspecified but out_valid timing is unaffected.
- Pipeline: 5 stages, fixed latency of 5 enabled cycles for both modes.
  - S1: register a, b, w, mode, valid, tag.
  - S2: mode 0 registers the product w*b. Mode 1 registers (a+b) mod Q and (a-b) mod Q.
  - S3: mode 0 registers the Barrett-reduced product, with a delayed alongside. Mode 1 registers the product diff*w, with sum delayed alongside.
  - S4: mode 0 registers the mod-Q sum and difference. Mode 1 registers the Barrett-reduced product, with sum delayed alongside.
  - S5: output registers.
- Each stage carries its own mode bit, so modes may change every cycle. Back-to-back mixed operations emerge in order with no bubbles. Throughput is 1 operation per enabled cycle.
- Datapath registers may load regardless of valid. out_valid is asserted only for issued operations. A_Out/B_Out/tag_out hold their last values when out_valid=0 (not forced to zero).
- ce=0: every stage, including the output registers, holds. Inputs are ignored that cycle. Latency is counted in ce=1 cycles only.
- ce and rst_n together: reset wins.
- No backpressure beyond ce. The consumer must accept out_valid whenever ce=1.

Test Plan:
- Reset, then mode 0 with a=1, b=1, w=17 -> after 5 cycles: out_valid=1, A_Out=18, B_Out=3313.
- Mode 1 with a=5, b=3, w=17 -> A_Out=8, B_Out=34. Mode 1 with a=3, b=5, w=17 -> A_Out=8, B_Out=3295 (exercises negative-difference wrap).
- Extremes, a=b=w=3328: mode 0 -> A_Out=0, B_Out=3327; mode 1 -> A_Out=3327, B_Out=0.
- 64 back-to-back operations with random mode, tag = index, random canonical a/b/w -> results match a golden model in order, tags sequential, out_valid continuous from cycle 5 to cycle 68.
- Issue 3 operations, deassert ce for 4 cycles mid-flight, then reassert -> outputs and out_valid frozen during stall; results appear 5 enabled cycles after issue, unchanged.
- Assert rst_n low with 4 operations in flight, release, idle -> out_valid stays 0 and all outputs read 0; no stale result emerges.
